// File: rtl/voltmeter_pkg.sv
// Shared definitions for the voltmeter digital top.
// Holds the conversion-scheduler state encoding, the range-select width and
// limit, and the auto-range / watchdog constants shared with state_machine.
package voltmeter_pkg;

    localparam int unsigned RANGE_W     = 3;
    localparam int unsigned MAX_RANGE   = 4;        // range 0 is the most sensitive
    localparam int unsigned DOWN_THRESH = 16'd1000; // counts below this step the range down
    localparam int unsigned MAX_RETRY   = 3;        // auto-range retries per request
    localparam int unsigned TIMEOUT     = 20'hFFFFF; // CONVERT watchdog limit in cycles

    typedef enum logic [2:0] {
        StIdle,
        StWaitRef,
        StStart,
        StConvert,
        StEval,
        StPublish
    } sched_state_e;

endpackage

// File: rtl/period_timer.sv
// Continuous-mode period timer.
// Down-counter that pulses tick_o when it reaches zero and then reloads from
// period_i, so a period of P yields one tick every P+1 cycles (P=0 ticks every
// cycle). While en_i is low the counter is held at its reload value.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   en_i           run enable (continuous mode)
//   period_i       reload value
//   tick_o         one-cycle tick at count zero
module period_timer #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] cur_cnt;
    // reload_q stands in for "counter holds period_i", so reset and disable
    // follow the live period input without an input-valued reset.
    logic                reload_q, reload_d;

    always_comb begin
        cur_cnt  = reload_q ? period_i : cnt_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tick_o   = 1'b0;
        if (!en_i) begin
            reload_d = 1'b1;
        end else if (cur_cnt == '0) begin
            tick_o   = 1'b1;
            reload_d = 1'b1;
        end else begin
            cnt_d    = cur_cnt - PERIOD_W'(1);
            reload_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            reload_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// Conversion scheduler above the measurement state machine/counter pair.
// Merges SPI one-shot and periodic requests into start/done handshakes with the
// measurement engine, auto-ranges on saturation/under-range, publishes a
// range-tagged result and drives a level interrupt.
//
// Optional build macro CONV_TIMEOUT_EN: adds a CONVERT watchdog that raises
// err_o/interrupt_o after TIMEOUT cycles without meas_done_i. Without it,
// CONVERT waits indefinitely and err_o is tied low.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   oneshot_req_i                one-cycle request from SPI decoder
//   cfg_continuous_i/period_i    periodic request enable and period
//   cfg_autorange_i/cfg_range_i  auto-range enable, fixed range otherwise
//   ref_ok_i                     reference good; gates conversion start
//   meas_start_o/meas_range_o    start pulse and range to measurement engine
//   meas_done_i/count_i/sat_i    completion pulse and result from engine
//   result_o/range_o/ovf_o       published result, valid_o strobes on update
//   busy_o                       scheduler not idle
//   overrun_o, err_o             sticky tick-overrun and timeout flags
//   irq_clr_i, interrupt_o       interrupt clear and level interrupt
module conv_scheduler
    import voltmeter_pkg::*;
#(
    parameter int unsigned RESULT_W = 16,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                oneshot_req_i,
    input  logic                cfg_continuous_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    input  logic                cfg_autorange_i,
    input  logic [RANGE_W-1:0]  cfg_range_i,
    input  logic                ref_ok_i,
    output logic                meas_start_o,
    output logic [RANGE_W-1:0]  meas_range_o,
    input  logic                meas_done_i,
    input  logic [RESULT_W-1:0] meas_count_i,
    input  logic                meas_sat_i,
    output logic [RESULT_W-1:0] result_o,
    output logic [RANGE_W-1:0]  result_range_o,
    output logic                result_ovf_o,
    output logic                result_valid_o,
    output logic                busy_o,
    output logic                overrun_o,
    output logic                err_o,
    input  logic                irq_clr_i,
    output logic                interrupt_o
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    sched_state_e        state_q, state_d;
    logic                pend_os_q, pend_os_d;
    logic                pend_tk_q, pend_tk_d;
    logic [RANGE_W-1:0]  cur_range_q, cur_range_d;
    logic [RANGE_W-1:0]  conv_range_q, conv_range_d;
    logic                auto_q, auto_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [RESULT_W-1:0] count_q, count_d;
    logic                sat_q, sat_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [RANGE_W-1:0]  result_range_q, result_range_d;
    logic                result_ovf_q, result_ovf_d;
    logic                interrupt_q, interrupt_d;
    logic                overrun_q, overrun_d;

    logic tick;
    logic timeout_evt;
    logic can_retry;
    logic step_up;
    logic step_dn;

`ifdef CONV_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
`endif

    period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_period_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (cfg_continuous_i),
        .period_i (cfg_period_i),
        .tick_o   (tick)
    );

    assign can_retry = retry_q < RETRY_W'(MAX_RETRY);
    assign step_up   = auto_q && sat_q && (conv_range_q < RANGE_W'(MAX_RANGE)) && can_retry;
    assign step_dn   = auto_q && !sat_q && (count_q < RESULT_W'(DOWN_THRESH)) &&
                       (conv_range_q != '0) && can_retry;

    always_comb begin
        state_d        = state_q;
        pend_os_d      = pend_os_q;
        pend_tk_d      = pend_tk_q;
        cur_range_d    = cur_range_q;
        conv_range_d   = conv_range_q;
        auto_d         = auto_q;
        retry_d        = retry_q;
        count_d        = count_q;
        sat_d          = sat_q;
        result_d       = result_q;
        result_range_d = result_range_q;
        result_ovf_d   = result_ovf_q;
        interrupt_d    = interrupt_q;
        overrun_d      = overrun_q;
        timeout_evt    = 1'b0;
        meas_start_o   = 1'b0;
        result_valid_o = 1'b0;
`ifdef CONV_TIMEOUT_EN
        wdog_d         = wdog_q;
        err_d          = err_q;
`endif

        // IDLE consumes live requests as well as latched ones, which is what
        // gives the two-cycle request-to-start latency; one conversion serves all.
        if (state_q == StIdle) begin
            pend_os_d = 1'b0;
            pend_tk_d = 1'b0;
        end else begin
            pend_os_d = pend_os_q | oneshot_req_i;
            pend_tk_d = pend_tk_q | tick;
        end

        unique case (state_q)
            StIdle: begin
                if (pend_os_q || pend_tk_q || oneshot_req_i || tick) begin
                    state_d = StWaitRef;
                end
            end
            StWaitRef: begin
                // Config is sampled here and held for the rest of the request.
                auto_d       = cfg_autorange_i;
                conv_range_d = cfg_autorange_i ? cur_range_q : cfg_range_i;
                if (ref_ok_i) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                meas_start_o = 1'b1;
                state_d      = StConvert;
`ifdef CONV_TIMEOUT_EN
                wdog_d       = '0;
`endif
            end
            StConvert: begin
                if (meas_done_i) begin
                    count_d = meas_count_i;
                    sat_d   = meas_sat_i;
                    state_d = StEval;
                end
`ifdef CONV_TIMEOUT_EN
                else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    timeout_evt = 1'b1;
                    err_d       = 1'b1;
                    retry_d     = '0;
                    state_d     = StIdle;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
`endif
            end
            StEval: begin
                if (step_up) begin
                    conv_range_d = conv_range_q + RANGE_W'(1);
                    cur_range_d  = conv_range_q + RANGE_W'(1);
                    retry_d      = retry_q + RETRY_W'(1);
                    state_d      = StStart;
                end else if (step_dn) begin
                    conv_range_d = conv_range_q - RANGE_W'(1);
                    cur_range_d  = conv_range_q - RANGE_W'(1);
                    retry_d      = retry_q + RETRY_W'(1);
                    state_d      = StStart;
                end else begin
                    // Results are loaded here so they are valid alongside the strobe.
                    result_d       = count_q;
                    result_range_d = conv_range_q;
                    result_ovf_d   = sat_q;
                    state_d        = StPublish;
                end
            end
            StPublish: begin
                result_valid_o = 1'b1;
                retry_d        = '0;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Clear first so a coincident set event wins.
        if (irq_clr_i) begin
            interrupt_d = 1'b0;
            overrun_d   = 1'b0;
`ifdef CONV_TIMEOUT_EN
            if (!timeout_evt) begin
                err_d = 1'b0;
            end
`endif
        end
        if (state_q == StPublish || timeout_evt) begin
            interrupt_d = 1'b1;
        end
        if (tick && pend_tk_q) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            pend_os_q      <= 1'b0;
            pend_tk_q      <= 1'b0;
            cur_range_q    <= '0;
            conv_range_q   <= '0;
            auto_q         <= 1'b0;
            retry_q        <= '0;
            count_q        <= '0;
            sat_q          <= 1'b0;
            result_q       <= '0;
            result_range_q <= '0;
            result_ovf_q   <= 1'b0;
            interrupt_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_os_q      <= pend_os_d;
            pend_tk_q      <= pend_tk_d;
            cur_range_q    <= cur_range_d;
            conv_range_q   <= conv_range_d;
            auto_q         <= auto_d;
            retry_q        <= retry_d;
            count_q        <= count_d;
            sat_q          <= sat_d;
            result_q       <= result_d;
            result_range_q <= result_range_d;
            result_ovf_q   <= result_ovf_d;
            interrupt_q    <= interrupt_d;
            overrun_q      <= overrun_d;
        end
    end

`ifdef CONV_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign meas_range_o   = conv_range_q;
    assign result_o       = result_q;
    assign result_range_o = result_range_q;
    assign result_ovf_o   = result_ovf_q;
    assign busy_o         = (state_q != StIdle);
    assign overrun_o      = overrun_q;
    assign interrupt_o    = interrupt_q;

endmodule
